dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Round-robin arbiter that shares the 256x8 two-port RAM (ports A and B) among `NUM_REQ` requesters. It grants up to two non-conflicting accesses per cycle, drives the RAM ports from registers, and routes read data back to the issuing requester with a fixed latency. It sits between the requester clients and the RAM instance and is the only driver of the RAM's port signals.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8. Address and data widths are fixed at 8 to match the RAM.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester access request; held with its fields until granted.
- `we`  in  NUM_REQ  per-requester access type: 1 = write, 0 = read.
- `addr`  in  8*NUM_REQ  packed addresses; requester i uses bits [8i+7:8i].
- `wdata`  in  8*NUM_REQ  packed write data, same packing as `addr`.
- `gnt`  out  NUM_REQ  combinational grant; request accepted in the cycle it is high.
- `rvalid`  out  NUM_REQ  registered, one-cycle pulse: read data for requester i is valid.
- `rdata`  out  8*NUM_REQ  registered read data, same packing; valid only with `rvalid[i]`.
- `ram_addr_A`, `ram_addr_B`  out  8  registered RAM port addresses.
- `ram_data_A`, `ram_data_B`  out  8  registered RAM write data.
- `ram_wr_en_A`, `ram_wr_en_B`  out  1  registered RAM write enables.
- `ram_q_A`, `ram_q_B`  in  8  RAM read outputs.

## Operation
- **Round-robin pointer.** `ptr` ranges 0..NUM_REQ-1 and resets to 0.
- **Each cycle, scan requesters in order `ptr`, `ptr+1`, … (mod NUM_REQ):**
  - The first requester with `req` high is granted on port A.
  - Scanning continues for a second requester to place on port B.
  - A candidate conflicts with the port-A access if the addresses are equal and either access is a write. Conflicting candidates are skipped and scanning continues.
  - The first non-conflicting candidate is granted on port B.
- **Pointer update.** If any grant occurs, `ptr` is set to (rotation index of the last granted requester + 1) mod NUM_REQ. Otherwise `ptr` holds.
- **Port registers.** On the edge ending the grant cycle, port A/B registers load the granted `addr`, `wdata`, and `we`.
  - An unused port loads `wr_en=0`, with `addr` and `data` held at their previous values.
  - Port tag pipeline: valid bit, requester index, is-read.
- **Read return.** The tag is delayed one more stage to align with `ram_q_*`. On the following edge, `rdata[i]` loads the port's `q` and `rvalid[i]` pulses for a tagged read.
- **Writes** produce no response.
- **Two reads to the same address** in one cycle are both granted, one per port.
- **Ordering.** A read returns data reflecting every write granted in an earlier cycle, and no write granted in the same or a later cycle.
- **No state machine beyond the pointer and pipelines.** A new grant is possible every cycle; throughput is up to 2 accesses per cycle.

## Timing
- **Read latency.** Grant in cycle N → port registers valid in N+1 → `ram_q` valid in N+2 → `rvalid`/`rdata` high in N+3. Fixed at 3 cycles, with no backpressure on `rvalid`.
- **Write completion.** A write granted in cycle N is committed to the RAM at the edge ending cycle N+1.
- **Grant rules.**
  - `gnt` depends combinationally on `req`, `we`, `addr`, and `ptr`.
  - At most two bits of `gnt` are high in any cycle.
  - `gnt[i]` is never high without `req[i]`.
- **Reset values.** `ptr=0`, all `ram_wr_en_*=0`, `ram_addr_*=0`, `ram_data_*=0`, all tag valids 0, `rvalid=0`, `rdata=0`. `gnt` is forced to 0 while `rst_n` is low.
- **Reset mid-operation.**
  - In-flight reads are discarded, and no `rvalid` appears after reset release for pre-reset grants.
  - A write already loaded into the port registers is cancelled (`wr_en` cleared asynchronously).
- **Same-address hazards.** Two writes to the same address in one cycle never reach the RAM: the second is deferred to a later cycle.

## Test plan
- **Single read after write.** Reset, write 0xA5 to addr 0x10 from requester 0, then read 0x10 from requester 1 on the next cycle → `rvalid[1]` exactly 3 cycles after its grant, with `rdata[1]`=0xA5.
- **Dual grant.** Requesters 0 and 2 both read distinct addresses 0x01/0x02 holding 0x11/0x22 → both granted in the same cycle, on ports A and B. Both `rvalid` pulses land in the same cycle with the correct data.
- **Write conflict.** Requesters 1 and 3 both write addr 0x40 (0x01 and 0x02), `ptr`=0 → only `gnt[1]` in the first cycle and `gnt[3]` in the next. A final read of 0x40 returns 0x02.
- **Fairness.** All 4 requesters issue continuous reads to distinct addresses → grants rotate {0,1}, {2,3}, {0,1}, … Each requester is granted every 2 cycles and none starves over 100 cycles.
- **Reset mid-operation.** Assert `rst_n` low one cycle after granting a read → no `rvalid` ever appears for it. All outputs read the reset values during reset, and `ptr` restarts at 0.
- **Read/write same cycle, same address.** Read and write to 0x80 requested together → they are serialized. The read returns the old value if granted first, or the new value if granted after.

Source files
------------

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin sharing of a two-port 256x8 RAM among NUM_REQ requesters
module dpram_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   we,
    input  logic [8*NUM_REQ-1:0] addr,
    input  logic [8*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rvalid,
    output logic [8*NUM_REQ-1:0] rdata,
    output logic [7:0]           ram_addr_A,
    output logic [7:0]           ram_addr_B,
    output logic [7:0]           ram_data_A,
    output logic [7:0]           ram_data_B,
    output logic                 ram_wr_en_A,
    output logic                 ram_wr_en_B,
    input  logic [7:0]           ram_q_A,
    input  logic [7:0]           ram_q_B
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr, ptr_nxt, cand;
    logic [IW-1:0] sel [2];
    logic          sel_v [2];
    logic [7:0]    a_arr [NUM_REQ];
    logic [7:0]    d_arr [NUM_REQ];
    logic [7:0]    rd_arr [NUM_REQ];
    logic [7:0]    p_addr [2];
    logic [7:0]    p_data [2];
    logic          p_we [2];
    logic          t1_v [2], t1_rd [2], t2_v [2], t2_rd [2];
    logic [IW-1:0] t1_id [2], t2_id [2];
    logic [7:0]    q [2];

    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = addr[8*i +: 8];
        assign d_arr[i] = wdata[8*i +: 8];
        assign rdata[8*i +: 8] = rd_arr[i];
    end

    assign q[0]        = ram_q_A;
    assign q[1]        = ram_q_B;
    assign ram_addr_A  = p_addr[0];
    assign ram_addr_B  = p_addr[1];
    assign ram_data_A  = p_data[0];
    assign ram_data_B  = p_data[1];
    assign ram_wr_en_A = p_we[0];
    assign ram_wr_en_B = p_we[1];

    // Rotating scan from ptr: first requester takes port A, first non-conflicting later one takes port B
    always_comb begin
        sel_v[0] = 1'b0;
        sel_v[1] = 1'b0;
        sel[0] = '0;
        sel[1] = '0;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rot(ptr, k);
            if (rst_n && req[cand]) begin
                if (!sel_v[0]) begin
                    sel_v[0] = 1'b1;
                    sel[0] = cand;
                end else if (!sel_v[1] && !(a_arr[cand] == a_arr[sel[0]] && (we[cand] || we[sel[0]]))) begin
                    sel_v[1] = 1'b1;
                    sel[1] = cand;
                end
            end
        end
    end

    // Grant vector and pointer advance past the last granted requester
    always_comb begin
        gnt = '0;
        for (int p = 0; p < 2; p++)
            if (sel_v[p]) gnt[sel[p]] = 1'b1;
        ptr_nxt = sel_v[1] ? rot(sel[1], 1) : sel_v[0] ? rot(sel[0], 1) : ptr;
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nxt;
    end

    // RAM port registers; an idle port keeps its address/data and only drops the write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                p_addr[p] <= '0;
                p_data[p] <= '0;
                p_we[p]   <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                p_we[p] <= sel_v[p] && we[sel[p]];
                if (sel_v[p]) begin
                    p_addr[p] <= a_arr[sel[p]];
                    p_data[p] <= d_arr[sel[p]];
                end
            end
        end
    end

    // Tag pipeline: stage 1 rides with the port registers, stage 2 lines up with ram_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                t1_v[p]  <= 1'b0;
                t1_rd[p] <= 1'b0;
                t1_id[p] <= '0;
                t2_v[p]  <= 1'b0;
                t2_rd[p] <= 1'b0;
                t2_id[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                t1_v[p]  <= sel_v[p];
                t1_rd[p] <= sel_v[p] && !we[sel[p]];
                t1_id[p] <= sel[p];
                t2_v[p]  <= t1_v[p];
                t2_rd[p] <= t1_rd[p];
                t2_id[p] <= t1_id[p];
            end
        end
    end

    // Read return: capture ram_q into the issuing requester's slot and pulse its rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            for (int i = 0; i < NUM_REQ; i++) rd_arr[i] <= '0;
        end else begin
            rvalid <= '0;
            for (int p = 0; p < 2; p++) begin
                if (t2_v[p] && t2_rd[p]) begin
                    rvalid[t2_id[p]] <= 1'b1;
                    rd_arr[t2_id[p]] <= q[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed checks of grants, port registers and read returns against a RAM model
module tb_dpram_arbiter;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req, we, gnt, rvalid;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  ram_addr_A, ram_addr_B, ram_data_A, ram_data_B, ram_q_A, ram_q_B;
    logic        ram_wr_en_A, ram_wr_en_B;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    int          cnt [4];

    dpram_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr_A(ram_addr_A), .ram_addr_B(ram_addr_B),
        .ram_data_A(ram_data_A), .ram_data_B(ram_data_B),
        .ram_wr_en_A(ram_wr_en_A), .ram_wr_en_B(ram_wr_en_B),
        .ram_q_A(ram_q_A), .ram_q_B(ram_q_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous two-port RAM, registered read output
    always @(posedge clk) begin
        if (ram_wr_en_A) mem[ram_addr_A] <= ram_data_A;
        if (ram_wr_en_B) mem[ram_addr_B] <= ram_data_B;
        ram_q_A <= mem[ram_addr_A];
        ram_q_B <= mem[ram_addr_B];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = r;
        we = w;
        addr = a;
        wdata = d;
        #4;
    endtask

    task automatic idle();
        cycle(4'b0000, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 'h0);
        check({tag, "_rvalid"}, 32'(rvalid), 'h0);
        check({tag, "_rdata"}, rdata, 'h0);
        check({tag, "_addrA"}, 32'(ram_addr_A), 'h0);
        check({tag, "_addrB"}, 32'(ram_addr_B), 'h0);
        check({tag, "_dataA"}, 32'(ram_data_A), 'h0);
        check({tag, "_dataB"}, 32'(ram_data_B), 'h0);
        check({tag, "_wrA"}, 32'(ram_wr_en_A), 'h0);
        check({tag, "_wrB"}, 32'(ram_wr_en_B), 'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'hF;
        we = 4'h0;
        addr = 32'h0;
        wdata = 32'h0;
        #12;
        check_reset_outputs("init");
        #10;
        req = 4'h0;
        rst_n = 1'b1;

        // Write 0xA5 to 0x10 from requester 0, then read it back from requester 1
        cycle(4'b0001, 4'b0001, {8'h0, 8'h0, 8'h0, 8'h10}, {8'h0, 8'h0, 8'h0, 8'hA5});
        check("raw_wgnt", 32'(gnt), 'h1);
        cycle(4'b0010, 4'b0000, {8'h0, 8'h0, 8'h10, 8'h0}, 32'h0);
        check("raw_rgnt", 32'(gnt), 'h2);
        check("raw_wrA", 32'(ram_wr_en_A), 'h1);
        check("raw_addrA", 32'(ram_addr_A), 'h10);
        check("raw_dataA", 32'(ram_data_A), 'hA5);
        check("raw_wrB_idle", 32'(ram_wr_en_B), 'h0);
        idle();
        check("raw_rv1", 32'(rvalid), 'h0);
        idle();
        check("raw_rv2", 32'(rvalid), 'h0);
        idle();
        check("raw_rv3", 32'(rvalid), 'h2);
        check("raw_rdata", 32'(rdata[15:8]), 'hA5);

        // Dual grant: preload 0x01/0x02, then read both in one cycle (ptr=2 then 1, so req2 on A)
        cycle(4'b0101, 4'b0101, {8'h0, 8'h02, 8'h0, 8'h01}, {8'h0, 8'h22, 8'h0, 8'h11});
        check("dual_wgnt", 32'(gnt), 'h5);
        cycle(4'b0101, 4'b0000, {8'h0, 8'h02, 8'h0, 8'h01}, 32'h0);
        check("dual_rgnt", 32'(gnt), 'h5);
        check("dual_wrA", 32'(ram_wr_en_A), 'h1);
        check("dual_wrB", 32'(ram_wr_en_B), 'h1);
        idle();
        check("dual_addrA", 32'(ram_addr_A), 'h02);
        check("dual_addrB", 32'(ram_addr_B), 'h01);
        check("dual_rd_wrA", 32'(ram_wr_en_A), 'h0);
        check("dual_rv1", 32'(rvalid), 'h0);
        idle();
        check("dual_rv2", 32'(rvalid), 'h0);
        idle();
        check("dual_rv3", 32'(rvalid), 'h5);
        check("dual_rdata0", 32'(rdata[7:0]), 'h11);
        check("dual_rdata2", 32'(rdata[23:16]), 'h22);

        // Bring ptr to 0 with a write from requester 3, then conflicting writes from 1 and 3
        cycle(4'b1000, 4'b1000, {8'h50, 8'h0, 8'h0, 8'h0}, {8'h33, 8'h0, 8'h0, 8'h0});
        check("wc_setup", 32'(gnt), 'h8);
        cycle(4'b1010, 4'b1010, {8'h40, 8'h0, 8'h40, 8'h0}, {8'h02, 8'h0, 8'h01, 8'h0});
        check("wc_gnt1", 32'(gnt), 'h2);
        cycle(4'b1000, 4'b1000, {8'h40, 8'h0, 8'h0, 8'h0}, {8'h02, 8'h0, 8'h0, 8'h0});
        check("wc_gnt3", 32'(gnt), 'h8);
        check("wc_wrA", 32'(ram_wr_en_A), 'h1);
        check("wc_wrB", 32'(ram_wr_en_B), 'h0);
        check("wc_dataA1", 32'(ram_data_A), 'h01);
        cycle(4'b0001, 4'b0000, {8'h0, 8'h0, 8'h0, 8'h40}, 32'h0);
        check("wc_rgnt", 32'(gnt), 'h1);
        check("wc_dataA3", 32'(ram_data_A), 'h02);
        idle();
        idle();
        check("wc_rv2", 32'(rvalid), 'h0);
        idle();
        check("wc_rv3", 32'(rvalid), 'h1);
        check("wc_rdata", 32'(rdata[7:0]), 'h02);

        // Reset one cycle after granting a read (B) and a write (A)
        cycle(4'b0011, 4'b0010, {8'h0, 8'h0, 8'h60, 8'h01}, {8'h0, 8'h0, 8'h77, 8'h0});
        check("rst_gnt_pre", 32'(gnt), 'h3);
        @(posedge clk);
        #1;
        check("rst_wr_loaded", 32'(ram_wr_en_A), 'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #2;
        check("rst_hold_rvalid", 32'(rvalid), 'h0);
        req = 4'h0;
        we = 4'h0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            check("rst_no_rvalid", 32'(rvalid), 'h0);
        end

        // Fairness: four continuous reads, ptr restarts at 0 so grants go {0,1},{2,3},...
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) cycle(4'b1111, 4'b0000, {8'hC3, 8'hC2, 8'hC1, 8'hC0}, 32'h0);
            else idle();
            check("fair_gnt", 32'(gnt), i >= 100 ? 'h0 : (i % 2 == 0) ? 'h3 : 'hC);
            check("fair_rvalid", 32'(rvalid), i < 3 ? 'h0 : ((i - 3) % 2 == 0) ? 'h3 : 'hC);
            for (int j = 0; j < 4; j++) if (gnt[j]) cnt[j]++;
        end
        for (int j = 0; j < 4; j++) check("fair_count", 32'(cnt[j]), 'd50);

        // Read and write to 0x80 together: serialized, read first sees the old value
        cycle(4'b0100, 4'b0100, {8'h0, 8'h80, 8'h0, 8'h0}, {8'h0, 8'h33, 8'h0, 8'h0});
        check("rw_pre", 32'(gnt), 'h4);
        cycle(4'b0011, 4'b0010, {8'h0, 8'h0, 8'h80, 8'h80}, {8'h0, 8'h0, 8'h44, 8'h0});
        check("rw_gnt_rd", 32'(gnt), 'h1);
        cycle(4'b0010, 4'b0010, {8'h0, 8'h0, 8'h80, 8'h0}, {8'h0, 8'h0, 8'h44, 8'h0});
        check("rw_gnt_wr", 32'(gnt), 'h2);
        cycle(4'b0100, 4'b0000, {8'h0, 8'h80, 8'h0, 8'h0}, 32'h0);
        check("rw_gnt_rd2", 32'(gnt), 'h4);
        check("rw_rv_early", 32'(rvalid), 'h0);
        idle();
        check("rw_rv_old", 32'(rvalid), 'h1);
        check("rw_old", 32'(rdata[7:0]), 'h33);
        idle();
        check("rw_rv_gap", 32'(rvalid), 'h0);
        idle();
        check("rw_rv_new", 32'(rvalid), 'h4);
        check("rw_new", 32'(rdata[23:16]), 'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
